secure_memory_engine: RTL and testbench



---
 rtl/secure_memory_engine.sv | 196 +++++++++++++++++++
 tb/tb_secure_memory_engine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/secure_memory_engine.sv
`timescale 1ns/1ps
// Nios II custom instruction: address-tweaked XOR encrypt on store, decrypt on load, via Avalon-MM.
// Latency: key/status/illegal done at cycle 1, read 3+W, write 3+W, timeout 2+T (read) / 3+T (write).
// Backpressure: honours waitrequest with strobes held stable; a stall counter aborts after TIMEOUT cycles.
module secure_memory_engine #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [DATA_W-1:0] KEY_DEFAULT = 32'h95DA4EAB,
  parameter bit                TWEAK_EN    = 1'b1,
  parameter int unsigned       TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     dataa,
  input  logic [ADDR_W-1:0]     datab,
  input  logic [2:0]            n,
  input  logic                  clk_en,
  input  logic                  start,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W-1:0]     readdata,
  input  logic                  waitrequest
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_XOR = 3'd1;
  localparam logic [2:0] RD_REQ = 3'd2;
  localparam logic [2:0] WR_REQ = 3'd3;
  localparam logic [2:0] RD_XOR = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int unsigned      CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ill_q, ill_d;
  logic              to_q, to_d;

  logic [DATA_W-1:0] addr_ks;
  logic [DATA_W-1:0] ks;
  logic              timeout_hit;
  logic              req_act;

  // Address folded to key width for the tweak: truncated when wider, zero-extended when narrower.
  if (ADDR_W >= DATA_W) begin : g_trunc
    assign addr_ks = addr_q[DATA_W-1:0];
  end else begin : g_zext
    assign addr_ks = {{(DATA_W - ADDR_W){1'b0}}, addr_q};
  end

  assign ks          = key_q ^ (TWEAK_EN ? addr_ks : '0);
  // The stall limit is checked one cycle after the last counted stall, so strobes drop exactly then.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LIM);
  assign req_act     = ((state_q == RD_REQ) || (state_q == WR_REQ)) && !timeout_hit;

  // Next-state and datapath: instruction accept, bus handshake, stall timeout and result formation.
  always_comb begin
    state_d  = state_q;
    dat_d    = dat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    key_d    = key_q;
    result_d = result_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    ill_d    = ill_q;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (start && clk_en) begin
          dat_d  = dataa;
          addr_d = datab;
          cnt_d  = '0;
          case (n)
            3'd0: state_d = RD_REQ;
            3'd1: state_d = WR_XOR;
            3'd2: begin
              key_d    = dataa;
              result_d = '0;
              done_d   = 1'b1;
              state_d  = DONE;
            end
            3'd3: begin
              key_d    = KEY_DEFAULT;
              result_d = '0;
              done_d   = 1'b1;
              state_d  = DONE;
            end
            3'd4: begin
              result_d      = '0;
              result_d[1:0] = {ill_q, to_q};
              ill_d         = 1'b0;
              to_d          = 1'b0;
              done_d        = 1'b1;
              state_d       = DONE;
            end
            default: begin
              result_d = '0;
              ill_d    = 1'b1;
              done_d   = 1'b1;
              state_d  = DONE;
            end
          endcase
        end
      end
      WR_XOR: begin
        wdata_d = dat_q ^ ks;
        state_d = WR_REQ;
      end
      RD_REQ, WR_REQ: begin
        if (timeout_hit) begin
          to_d     = 1'b1;
          result_d = '0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (!waitrequest) begin
          if (state_q == RD_REQ) begin
            rdata_d = readdata;
            state_d = RD_XOR;
          end else begin
            result_d = wdata_q;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_XOR: begin
        result_d = rdata_q ^ ks;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset restores the default key and aborts any in-flight transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dat_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      key_q    <= KEY_DEFAULT;
      result_q <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dat_q    <= dat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      key_q    <= key_d;
      result_q <= result_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      ill_q    <= ill_d;
      to_q     <= to_d;
    end
  end

  // Avalon outputs decode from registered state only, so they are zero whenever no transfer is live.
  always_comb begin
    chipselect = req_act;
    read       = req_act && (state_q == RD_REQ);
    write      = req_act && (state_q == WR_REQ);
    address    = req_act ? addr_q : '0;
    byteenable = req_act ? '1 : '0;
    writedata  = (req_act && (state_q == WR_REQ)) ? wdata_q : '0;
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_secure_memory_engine.sv
`timescale 1ns/1ps
// Directed bench for secure_memory_engine with TIMEOUT=4 and a result scoreboard.
// Each instruction pushes its expected outcome; the entry is popped and compared on done.
// waitrequest is driven per transfer from a requested stall count.
module tb_secure_memory_engine;

  logic        clk;
  logic        reset;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [2:0]  n;
  logic        clk_en;
  logic        start;
  logic        done;
  logic [31:0] result;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [31:0] wd;
    int          nwr;
    int          nrd;
  } exp_t;

  exp_t sb[$];

  secure_memory_engine #(
    .DATA_W(32), .ADDR_W(32), .KEY_DEFAULT(32'h95DA4EAB), .TWEAK_EN(1'b1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .dataa(dataa), .datab(datab), .n(n), .clk_en(clk_en),
    .start(start), .done(done), .result(result), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE (#1 after an edge); returns #1 after the edge following done.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int w, input logic [31:0] rd,
                        input bit spurious, input logic [31:0] exp_res, input int exp_cyc,
                        input logic [31:0] exp_wd, input int exp_wr, input int exp_rd);
    exp_t e;
    int   nwr, nrd, stalls, cyc;
    bit   got, stable;
    logic [31:0] wd_seen;
    sb.push_back('{exp_res, exp_cyc, exp_wd, exp_wr, exp_rd});
    dataa = a; datab = b; n = op; readdata = rd; start = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clk_en = 1'b0;
    dataa = 32'hDEADBEEF; datab = 32'hFFFFFFF0;
    nwr = 0; nrd = 0; stalls = 0; cyc = 0; got = 1'b0; stable = 1'b1; wd_seen = '0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (spurious && c == 2) begin
        start = 1'b1; clk_en = 1'b1; n = 3'd2; dataa = 32'hFFFFFFFF;
      end else begin
        start = 1'b0; clk_en = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        cyc = c;
      end else begin
        if (chipselect) begin
          if (address !== b || byteenable !== 4'hF) stable = 1'b0;
          if (write) begin nwr++; wd_seen = writedata; end
          if (read) nrd++;
          waitrequest = (stalls < w);
          if (waitrequest) stalls++;
        end else begin
          waitrequest = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_wr_cycles"}, 32'(nwr), 32'(e.nwr));
    chk({tag, "_rd_cycles"}, 32'(nrd), 32'(e.nrd));
    chk({tag, "_writedata"}, wd_seen, e.wd);
    chk({tag, "_addr_stable"}, 32'(stable), 32'd1);
    chk({tag, "_bus_idle_at_done"}, {28'd0, chipselect, read, write, |byteenable}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; clk_en = 1'b0; n = '0; dataa = '0; datab = '0;
    readdata = '0; waitrequest = 1'b0;
    #12;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_bus", {27'd0, chipselect, read, write, byteenable != 4'd0, address != 32'd0}, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Default key, address tweak 0x10.
    run_op("wr_basic", 3'd1, 32'h12345678, 32'h10, 0, 32'h0, 1'b0,
           32'h87EE18C3, 3, 32'h87EE18C3, 1, 0);
    // Two stalls; a start during the transfer must be ignored.
    run_op("rd_stall2", 3'd0, 32'h0, 32'h10, 2, 32'h87EE18C3, 1'b1,
           32'h12345678, 5, 32'h0, 0, 3);
    // Key must still be the default after the ignored start.
    run_op("wr_key_kept", 3'd1, 32'h12345678, 32'h10, 0, 32'h0, 1'b0,
           32'h87EE18C3, 3, 32'h87EE18C3, 1, 0);
    run_op("load_key0", 3'd2, 32'h00000000, 32'h0, 0, 32'h0, 1'b0, 32'h0, 1, 32'h0, 0, 0);
    run_op("wr_key0", 3'd1, 32'hAAAA5555, 32'h4, 1, 32'h0, 1'b0,
           32'hAAAA5551, 4, 32'hAAAA5551, 2, 0);
    run_op("reset_key", 3'd3, 32'h1234, 32'h0, 0, 32'h0, 1'b0, 32'h0, 1, 32'h0, 0, 0);
    run_op("wr_keydef", 3'd1, 32'hAAAA5555, 32'h4, 0, 32'h0, 1'b0,
           32'h3F701BFA, 3, 32'h3F701BFA, 1, 0);

    // Stall timeout on a read, then sticky status read and clear.
    run_op("rd_timeout", 3'd0, 32'h0, 32'h20, 100, 32'h5A5A5A5A, 1'b0,
           32'h0, 6, 32'h0, 0, 4);
    run_op("status_to", 3'd4, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'h1, 1, 32'h0, 0, 0);
    run_op("status_clr", 3'd4, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'h0, 1, 32'h0, 0, 0);
    run_op("illegal6", 3'd6, 32'hFFFF, 32'h0, 0, 32'h0, 1'b0, 32'h0, 1, 32'h0, 0, 0);
    run_op("status_ill", 3'd4, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'h2, 1, 32'h0, 0, 0);
    // Stall timeout on a write: ciphertext of 0 at address 0 is the default key.
    run_op("wr_timeout", 3'd1, 32'h0, 32'h0, 100, 32'h0, 1'b0,
           32'h0, 7, 32'h95DA4EAB, 4, 0);
    run_op("status_to2", 3'd4, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'h1, 1, 32'h0, 0, 0);

    // Non-default key, then reset in the middle of a stalled write.
    run_op("load_key1", 3'd2, 32'h11111111, 32'h0, 0, 32'h0, 1'b0, 32'h0, 1, 32'h0, 0, 0);
    dataa = 32'h0BADF00D; datab = 32'h8; n = 3'd1; start = 1'b1; clk_en = 1'b1;
    waitrequest = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clk_en = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen < 2; c++) begin
      if (chipselect && write) seen++;
      if (seen < 2) begin @(posedge clk); #1; end
    end
    chk("rst_mid_reached_req", 32'(seen), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_async_bus", {29'd0, chipselect, write, read}, 32'd0);
    chk("rst_mid_addr", address, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    waitrequest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {30'd0, done, chipselect}, 32'd0);
    end
    run_op("rd_after_rst", 3'd0, 32'h0, 32'h10, 0, 32'h87EE18C3, 1'b0,
           32'h12345678, 3, 32'h0, 0, 1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
